// File: rtl/gpio_edge_irq_pkg.sv
// Shared defaults for the GPIO input path, also used by GPIO_core.
// Keeping them here gives both blocks the same reset-time configuration.
package gpio_edge_irq_pkg;

  localparam int DEFAULT_WIDTH_PORT      = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_W           = 3;

endpackage

// File: rtl/gpio_edge_irq_debounce_bit.sv
// One GPIO bit: 2-flop synchronizer, debounce counter and accepted level.
// upd_o strobes for one cycle when the next edge will load a new level.
module gpio_edge_irq_debounce_bit
  import gpio_edge_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic pin_i,
  output logic sample_o,
  output logic level_o,
  output logic upd_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  assign mismatch = (sync2 != level);
  assign upd_o    = mismatch && (cnt == CNT_LAST);
  assign sample_o = sync2;
  assign level_o  = level;

  // cnt counts consecutive mismatching synced samples; any agreement restarts it.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pin_i;
      sync2 <= sync1;
      if (!mismatch) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_edge_irq.sv
// Debounced GPIO input levels with per-bit edge qualification,
// sticky pending flags and one maskable, registered interrupt line.
module gpio_edge_irq
  import gpio_edge_irq_pkg::*;
#(
  parameter int WIDTH_PORT      = DEFAULT_WIDTH_PORT,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [WIDTH_PORT-1:0] gpio_i,
  input  logic [WIDTH_PORT-1:0] rise_en_i,
  input  logic [WIDTH_PORT-1:0] fall_en_i,
  input  logic [WIDTH_PORT-1:0] mask_i,
  input  logic [WIDTH_PORT-1:0] clr_i,
  output logic [WIDTH_PORT-1:0] level_o,
  output logic [WIDTH_PORT-1:0] pending_o,
  output logic                  irq_o
);

  logic [WIDTH_PORT-1:0] sample;
  logic [WIDTH_PORT-1:0] upd;
  logic [WIDTH_PORT-1:0] rise;
  logic [WIDTH_PORT-1:0] fall;
  logic [WIDTH_PORT-1:0] pending;
  logic [WIDTH_PORT-1:0] pending_next;
  logic                  irq;

  for (genvar i = 0; i < WIDTH_PORT; i++) begin : g_bit
    gpio_edge_irq_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk_i   (clk_i),
      .resetn_i(resetn_i),
      .pin_i   (gpio_i[i]),
      .sample_o(sample[i]),
      .level_o (level_o[i]),
      .upd_o   (upd[i])
    );
  end

  // The new level equals the synced sample on the update cycle, so it gives the direction.
  assign rise = upd & sample & rise_en_i;
  assign fall = upd & ~sample & fall_en_i;

  // Sets are ORed in after the clear so a coincident event is never lost.
  assign pending_next = (pending & ~clr_i) | rise | fall;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      pending <= pending_next;
      irq     <= |(pending & mask_i);
    end
  end

  assign pending_o = pending;
  assign irq_o     = irq;

endmodule

// File: tb/tb_gpio_edge_irq.sv
// Directed bench for gpio_edge_irq: a table of timed vectors for the main
// paths plus hand-written sequences for collision, masking and mid-debounce reset.
module tb_gpio_edge_irq;

  logic       clk;
  logic       resetn;
  logic [7:0] gpio;
  logic [7:0] rise_en;
  logic [7:0] fall_en;
  logic [7:0] mask;
  logic [7:0] clr;
  logic [7:0] level;
  logic [7:0] pending;
  logic       irq;

  int checks;
  int passes;

  typedef struct {
    string      name;
    logic [7:0] gpio;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] mask;
    logic [7:0] clr;
    int         cycles;
    logic [7:0] exp_level;
    logic [7:0] exp_pending;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[16];

  gpio_edge_irq #(
    .WIDTH_PORT     (8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .gpio_i   (gpio),
    .rise_en_i(rise_en),
    .fall_en_i(fall_en),
    .mask_i   (mask),
    .clr_i    (clr),
    .level_o  (level),
    .pending_o(pending),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input vec_t v);
    gpio    = v.gpio;
    rise_en = v.rise_en;
    fall_en = v.fall_en;
    mask    = v.mask;
    clr     = v.clr;
  endtask

  initial begin
    checks  = 0;
    passes  = 0;
    resetn  = 1'b0;
    gpio    = 8'hFF;
    rise_en = 8'h00;
    fall_en = 8'h00;
    mask    = 8'h00;
    clr     = 8'h00;

    //          name           gpio   rise   fall   mask   clr  cyc  level  pend  irq
    vecs[0]  = '{"rise_wait",  8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 5, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{"rise_upd",   8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 1, 8'h01, 8'h01, 1'b0};
    vecs[2]  = '{"rise_irq",   8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 1, 8'h01, 8'h01, 1'b1};
    vecs[3]  = '{"rise_clr",   8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 1, 8'h01, 8'h00, 1'b1};
    vecs[4]  = '{"rise_irq0",  8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 1, 8'h01, 8'h00, 1'b0};
    vecs[5]  = '{"glitch_on",  8'h03, 8'h03, 8'h00, 8'h01, 8'h00, 3, 8'h01, 8'h00, 1'b0};
    vecs[6]  = '{"glitch_off", 8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8, 8'h01, 8'h00, 1'b0};
    vecs[7]  = '{"p2_up",      8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 6, 8'h05, 8'h00, 1'b0};
    vecs[8]  = '{"p2_fall_dis",8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 6, 8'h01, 8'h00, 1'b0};
    vecs[9]  = '{"p2_up2",     8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 6, 8'h05, 8'h00, 1'b0};
    vecs[10] = '{"p2_fall_w",  8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 5, 8'h05, 8'h00, 1'b0};
    vecs[11] = '{"p2_fall_en", 8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 1, 8'h01, 8'h04, 1'b0};
    vecs[12] = '{"en_off_kept",8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h01, 8'h04, 1'b0};
    vecs[13] = '{"mask_on",    8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 1, 8'h01, 8'h04, 1'b1};
    vecs[14] = '{"p2_clr",     8'h01, 8'h00, 8'h00, 8'h04, 8'h04, 1, 8'h01, 8'h00, 1'b1};
    vecs[15] = '{"p2_irq0",    8'h01, 8'h00, 8'h00, 8'h04, 8'h00, 1, 8'h01, 8'h00, 1'b0};

    #1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("rst_level", level, 8'h00);
      checkOutput("rst_pending", pending, 8'h00);
      checkOutput("rst_irq", {7'b0, irq}, 8'h00);
    end

    // Pins held high through reset are accepted as a rise after release.
    resetn = 1'b1;
    tick(5);
    checkOutput("post_rst_wait", level, 8'h00);
    tick(1);
    checkOutput("post_rst_level", level, 8'hFF);
    checkOutput("post_rst_pend", pending, 8'h00);
    gpio = 8'h00;
    tick(6);
    checkOutput("all_low", level, 8'h00);
    checkOutput("all_low_pend", pending, 8'h00);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i]);
      tick(vecs[i].cycles);
      checkOutput({vecs[i].name, "_level"}, level, vecs[i].exp_level);
      checkOutput({vecs[i].name, "_pending"}, pending, vecs[i].exp_pending);
      checkOutput({vecs[i].name, "_irq"}, {7'b0, irq}, {7'b0, vecs[i].exp_irq});
    end

    // Clear and rise on bit 3 in the same cycle: the set must win.
    gpio = 8'h09; rise_en = 8'h08; fall_en = 8'h00; mask = 8'h00; clr = 8'h00;
    tick(5);
    checkOutput("coll_wait", level, 8'h01);
    clr = 8'h08;
    tick(1);
    checkOutput("coll_level", level, 8'h09);
    checkOutput("coll_pending", pending, 8'h08);
    clr = 8'h00;
    tick(1);
    checkOutput("coll_hold", pending, 8'h08);
    clr = 8'h08;
    tick(1);
    clr = 8'h00;
    checkOutput("coll_cleared", pending, 8'h00);

    // Masked pending on bit 4, then unmask.
    gpio = 8'h19; rise_en = 8'h10;
    tick(6);
    checkOutput("mask_pend", pending, 8'h10);
    tick(2);
    checkOutput("masked_irq", {7'b0, irq}, 8'h00);
    mask = 8'h10;
    tick(1);
    checkOutput("unmasked_irq", {7'b0, irq}, 8'h01);

    // Reset while bit 5 is two counts into its debounce.
    gpio = 8'h39;
    tick(4);
    checkOutput("mid_level", level, 8'h19);
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_level", level, 8'h00);
    checkOutput("mid_rst_pend", pending, 8'h00);
    checkOutput("mid_rst_irq", {7'b0, irq}, 8'h00);
    tick(2);
    resetn = 1'b1;
    tick(5);
    checkOutput("restart_wait", level, 8'h00);
    tick(1);
    checkOutput("restart_level", level, 8'h39);
    checkOutput("restart_pend", pending, 8'h10);
    tick(1);
    checkOutput("restart_irq", {7'b0, irq}, 8'h01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
